// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit path.
// Used by usb_tx_fifo and usb_tx_fifo_mem.
package usb_pkg;

    typedef logic [15:0] usb_word_t;

    localparam logic [7:0] USB_PAD_BYTE = 8'h00;

    typedef enum logic {
        PK_IDLE = 1'b0,
        PK_HALF = 1'b1
    } pack_state_e;

    // Little-endian pairing: the earlier byte lands in the low half of the word.
    function automatic usb_word_t pack_word(input logic [7:0] first_byte,
                                            input logic [7:0] second_byte);
        return {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/usb_tx_fifo_mem.sv
// Circular word store for the USB TX FIFO.
// Holds the pointers, the occupancy count and the show-ahead head word.
import usb_pkg::*;

module usb_tx_fifo_mem #(
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              push,
    input  usb_word_t         push_data,
    input  logic              pop_req,
    output usb_word_t         head_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    usb_word_t         mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_FULL);
    assign count = count_q;

    assign head_data = empty ? usb_word_t'(16'h0000) : mem_q[rptr_q];

    // A pop on an empty queue is dropped; the caller never pushes while full.
    assign do_push = push && !full && !clear;
    assign do_pop  = pop_req && !empty && !clear;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset and flush; stale words are masked by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/usb_tx_fifo.sv
// Byte-to-word packer plus circular FIFO feeding the USB TX stage.
// Define USB_TX_FIFO_ERR_EN to add sticky overflow_err/underflow_err outputs.
import usb_pkg::*;

module usb_tx_fifo #(
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fifo_clear,
    input  logic [7:0]        wr_byte,
    input  logic              wr_valid,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              read_enable,
    output logic [15:0]       tx_data,
    output logic              transmit_empty,
`ifdef USB_TX_FIFO_ERR_EN
    output logic              overflow_err,
    output logic              underflow_err,
`endif
    output logic [ADDR_W:0]   word_count
);

    pack_state_e state_q, state_d;
    logic [7:0]  half_byte_q, half_byte_d;
    logic        accept;
    logic        push;
    usb_word_t   push_word;
    usb_word_t   head_word;
    logic        fifo_empty;
    logic        fifo_full;

    // Back-pressure only when the incoming byte would complete a word and there is no room.
    assign wr_ready = !(fifo_full && ((state_q == PK_HALF) || wr_last));
    assign accept   = wr_valid && wr_ready && !fifo_clear;
    assign push     = accept && ((state_q == PK_HALF) || wr_last);

    always_comb begin
        push_word = pack_word(wr_byte, USB_PAD_BYTE);
        if (state_q == PK_HALF) begin
            push_word = pack_word(half_byte_q, wr_byte);
        end
    end

    always_comb begin
        state_d     = state_q;
        half_byte_d = half_byte_q;
        if (fifo_clear) begin
            state_d     = PK_IDLE;
            half_byte_d = '0;
        end else if (accept) begin
            case (state_q)
                PK_IDLE: begin
                    if (!wr_last) begin
                        state_d     = PK_HALF;
                        half_byte_d = wr_byte;
                    end
                end
                PK_HALF: state_d = PK_IDLE;
                default: state_d = PK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= PK_IDLE;
            half_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            half_byte_q <= half_byte_d;
        end
    end

    usb_tx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (fifo_clear),
        .push      (push),
        .push_data (push_word),
        .pop_req   (read_enable),
        .head_data (head_word),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (word_count)
    );

    assign tx_data        = head_word;
    assign transmit_empty = fifo_empty;

`ifdef USB_TX_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (fifo_clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_valid && !wr_ready) begin
                overflow_d = 1'b1;
            end
            if (read_enable && fifo_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
`endif

endmodule
